// File: rtl/uart_char_pkg.sv
// Shared types and constants for the UART character receiver.
package uart_char_pkg;

    localparam int   CHAR_W   = 8;
    localparam logic RXD_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_char_rx_if.sv
// Character output channel of uart_char_rx: one-entry valid/ready register plus error pulses.
interface uart_char_rx_if;
    import uart_char_pkg::*;

    logic [CHAR_W-1:0] out_char;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;

    modport master (
        output out_char,
        output out_valid,
        input  out_ready,
        output frame_err,
        output parity_err,
        output overrun
    );

    modport slave (
        input  out_char,
        input  out_valid,
        output out_ready,
        input  frame_err,
        input  parity_err,
        input  overrun
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: ticks at the mid-bit point (half) or the end of a full bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic half,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt;

    assign tick = !restart && (cnt == (half ? HALF_LAST : FULL_LAST));

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 UART character receiver with a one-entry valid/ready output register.
// Define UART_CHAR_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_char_rx
    import uart_char_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rxd,
    uart_char_rx_if.master rx
);
    rx_state_t         state;
    logic              rx_meta;
    logic              rxs;
    logic [2:0]        bitn;
    logic [CHAR_W-1:0] shreg;
    logic              tick;
    logic              vld_p0;
    logic [CHAR_W-1:0] char_p0;
    logic              ferr_p0;
`ifdef UART_CHAR_RX_PARITY_EN
    logic              par_bad;
    logic              perr_p0;
`else
    localparam logic   par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= RXD_IDLE;
            rxs     <= RXD_IDLE;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Counter is held at zero while waiting for an edge, so every timed state starts fresh.
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart ((state == IDLE) || (state == BREAK)),
        .half    (state == START),
        .tick    (tick)
    );

    // Stage p0: frame FSM, result strobes registered at the stop-bit sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bitn    <= '0;
            shreg   <= '0;
            vld_p0  <= 1'b0;
            char_p0 <= '0;
            ferr_p0 <= 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_p0 <= 1'b0;
`endif
        end else begin
            vld_p0  <= 1'b0;
            ferr_p0 <= 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
            perr_p0 <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (rxs != RXD_IDLE) begin
                        bitn  <= '0;
                        state <= START;
`ifdef UART_CHAR_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick) state <= (rxs == RXD_IDLE) ? IDLE : DATA;
                end
                DATA: begin
                    if (tick) begin
                        shreg[bitn] <= rxs;
                        if (bitn == 3'd7) begin
`ifdef UART_CHAR_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end
                end
`ifdef UART_CHAR_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        par_bad <= ^{shreg, rxs};
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
`ifdef UART_CHAR_RX_PARITY_EN
                        perr_p0 <= par_bad;
`endif
                        if (rxs == RXD_IDLE) begin
                            vld_p0  <= !par_bad;
                            char_p0 <= shreg;
                            state   <= IDLE;
                        end else begin
                            ferr_p0 <= 1'b1;
                            state   <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs == RXD_IDLE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: one-entry output register; a held character is never overwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            rx.out_char  <= '0;
            rx.out_valid <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
        end else begin
            rx.frame_err <= ferr_p0;
            rx.overrun   <= 1'b0;
            if (vld_p0) begin
                if (!rx.out_valid || rx.out_ready) begin
                    rx.out_char  <= char_p0;
                    rx.out_valid <= 1'b1;
                end else begin
                    rx.overrun <= 1'b1;
                end
            end else if (rx.out_valid && rx.out_ready) begin
                rx.out_valid <= 1'b0;
            end
        end
    end

`ifdef UART_CHAR_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) rx.parity_err <= 1'b0;
        else     rx.parity_err <= perr_p0;
    end
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_char_rx.md
# uart_char_rx

Serial character receiver that sits directly upstream of the ASCII case-conversion stage. It samples an asynchronous 8N1 UART line and assembles one 8-bit character per frame. It presents each character on a one-entry valid/ready output register whose data bus feeds the converter's `in[7:0]`. It also flags framing errors and overrun.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16, clock cycles per UART bit period; must be an even number of at least 4.

Ports:
- `clk`: input, 1 bit. Single system clock; all state updates on its rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `rxd`: input, 1 bit. Asynchronous serial line; idles high.
- `out_char`: output, 8 bits. Received character, LSB first on the line. Drives the converter's input.
- `out_valid`: output, 1 bit. `out_char` holds an unconsumed character.
- `out_ready`: input, 1 bit. The consumer accepts `out_char` this cycle.
- `frame_err`: output, 1 bit. One-cycle pulse when the stop bit is sampled as 0.
- `parity_err`: output, 1 bit. One-cycle pulse on a parity mismatch. Tied to 0 when parity is compiled out.
- `overrun`: output, 1 bit. One-cycle pulse when a new character completes while the held character cannot be replaced.

## Operation
- `rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All FSM decisions use the second flop, `rxs`.
- FSM states:
  - IDLE: when `rxs`=0, clear the bit counter and go to START.
  - START: wait `CLKS_PER_BIT/2` cycles, then resample. If `rxs`=1 it was a false start; go to IDLE. If `rxs`=0, go to DATA.
  - DATA: wait `CLKS_PER_BIT` cycles, then shift `rxs` into bit[n], n=0..7. After bit 7 go to STOP, or to PARITY when that feature is compiled in.
  - STOP: wait `CLKS_PER_BIT` cycles, then sample. If 1, deliver the character and go to IDLE. If 0, pulse `frame_err`, discard the character, and go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE.
- Timing counters:
  - The bit-period counter counts 0..`CLKS_PER_BIT`-1 and reloads on every state change.
  - The bit index is 3 bits wide and does not wrap within a frame.
- Output register:
  - Delivery: if `out_valid`=0, or if `out_valid && out_ready` in the same cycle, load `out_char` and set `out_valid`=1.
  - Otherwise pulse `overrun`, drop the new character, and keep the held `out_char` unchanged.
- Handshake:
  - A transfer occurs on any cycle with `out_valid && out_ready`.
  - After a transfer with no simultaneous delivery, `out_valid` is 0 on the next cycle.
  - `out_char` stays stable while `out_valid`=1.
  - `out_ready` is a don't-care while `out_valid`=0.

## Timing
- Reset values: `out_char`=0x00, `out_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. FSM is in IDLE, counters are 0, synchronizer flops are 1.
- Reset mid-frame: the cycle after `rst` is sampled high, all state equals the reset values and any partial character is lost.
- Latency, measured from the first rising edge at which `rxd`=0 is captured:
  - `out_valid` rises 2 + `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT` + 1 cycles later.
  - With `CLKS_PER_BIT`=16 this is 155 cycles.
  - Add `CLKS_PER_BIT` cycles when parity is enabled.
- Pulse timing: `frame_err`, `parity_err` and `overrun` are registered. Each is high for exactly one cycle, the cycle `out_valid` would have risen.
- Back-to-back frames: a start bit that arrives immediately after the stop sample is detected with no lost cycles.

## Configuration
- `UART_CHAR_RX_PARITY_EN` defined:
  - Adds a PARITY state after DATA, lasting `CLKS_PER_BIT` cycles.
  - Uses even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: pulse `parity_err`, discard the character, continue to STOP as normal. A subsequent stop error still pulses `frame_err`.
- Undefined: there is no PARITY state, `parity_err` is tied to 0, and the frame is 8N1.

## Structure
- Package `uart_char_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `CHAR_W`=8;
  - the `RXD_IDLE`=1 constant.
- Sub-module `uart_bit_timer`:
  - Holds the bit-period counter.
  - Inputs: `clk`, `rst`, restart, half.
  - Output: `tick` pulse at the mid-bit or end-of-bit point.
- The FSM and the output register stay in `uart_char_rx`.

## Test plan
- Idle line, then frame 0x61 ('a') with `CLKS_PER_BIT`=16 and `out_ready`=1 -> `out_valid` high at cycle 155 for exactly 1 cycle, with `out_char`=0x61.
- `rxd` low for 3 cycles, then high -> no `out_valid`, no error pulses, FSM returns to IDLE.
- Frame 0x7A with stop bit 0 -> `frame_err` one-cycle pulse, `out_valid` stays 0. With `rxd` held low, no new frame starts until the line returns high.
- `out_ready`=0, frames 0x41 then 0x42 -> `out_valid`=1 with `out_char`=0x41, `overrun` pulses at the second delivery, and `out_char` remains 0x41.
- `rst` asserted midway through data bit 4 of 0x55 -> on the next cycle all outputs are 0 and the FSM is in IDLE. A following frame 0x55 is received correctly.
- With `UART_CHAR_RX_PARITY_EN`, frame 0x03 with parity bit 1 -> `parity_err` pulse and no `out_valid`. The same frame with parity bit 0 -> `out_char`=0x03 at cycle 171.
